fetch_ctrl: RTL and testbench

Sequencing controller for the instruction fetch unit (`ifu`). It performs the boot load of the reset vector and converts execute-stage branch and jump resolutions into the IFU's `branch`/`zero`/`msb`/`pc_ld`/`pc_data` controls. It also holds the PC under decode back-pressure and squashes wrong-path instructions before they reach decode. It sits between `ifu` and the decode stage.

---
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller between the instruction fetch unit (ifu)
// and decode. It boot-loads the reset vector, turns execute-stage branch and
// jump resolutions into IFU controls, holds the PC under decode stall, and
// squashes wrong-path instructions for FLUSH_CYCLES cycles after a redirect.
//
// Parameters : RESET_VECTOR  PC loaded at boot
//              FLUSH_CYCLES  bubbles after a taken redirect (1..7)
// Inputs     : clk, rst_n (async, active-low), stall, br_req, br_type[1:0],
//              alu_zero, alu_msb, jmp_req, jmp_target[31:0], ifu_pc[31:0],
//              ifu_instr[31:0]
// Outputs    : ifu_branch[1:0], ifu_zero, ifu_msb, ifu_pc_ld,
//              ifu_pc_data[31:0]  (combinational IFU controls)
//              instr_out[31:0], instr_valid (registered decode output)
//              flushing, fetch_cnt[15:0], flush_cnt[15:0]
// Build option: define FETCH_CTRL_PERF_EN to build the saturating
//              fetch/flush performance counters; otherwise both read 0.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0010_0008,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_req,
  input  logic [1:0]  br_type,
  input  logic        alu_zero,
  input  logic        alu_msb,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic [31:0] ifu_pc,
  input  logic [31:0] ifu_instr,
  output logic [1:0]  ifu_branch,
  output logic        ifu_zero,
  output logic        ifu_msb,
  output logic        ifu_pc_ld,
  output logic [31:0] ifu_pc_data,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        flushing,
  output logic [15:0] fetch_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  flush_left_q, flush_left_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        capture;      // accept ifu_instr as a new in-path instruction
  logic        flush_enter;  // taken redirect this cycle
  logic        br_taken;

  assign br_taken = (br_type == 2'b01 &&  alu_zero) ||
                    (br_type == 2'b10 && !alu_zero) ||
                    (br_type == 2'b11 &&  alu_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      flush_left_q <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    ifu_branch   = 2'b00;
    ifu_zero     = 1'b0;
    ifu_msb      = 1'b0;
    ifu_pc_ld    = 1'b0;
    ifu_pc_data  = '0;
    capture      = 1'b0;
    flush_enter  = 1'b0;

    case (state_q)
      S_BOOT: begin
        ifu_pc_ld   = 1'b1;
        ifu_pc_data = RESET_VECTOR;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (jmp_req) begin
          ifu_pc_ld   = 1'b1;
          ifu_pc_data = jmp_target;
          flush_enter = 1'b1;
        end else if (br_req) begin
          ifu_branch = br_type;
          ifu_zero   = alu_zero;
          ifu_msb    = alu_msb;
          if (br_taken) flush_enter = 1'b1;
          else          capture     = 1'b1;
        end else if (stall) begin
          ifu_pc_ld   = 1'b1;
          ifu_pc_data = ifu_pc;
        end else begin
          capture = 1'b1;
        end
      end
      S_FLUSH: begin
        // Redirect requests here come from squashed instructions: ignored.
        if (stall) begin
          ifu_pc_ld   = 1'b1;
          ifu_pc_data = ifu_pc;
        end
        if (flush_left_q == 3'd0) begin
          state_d = S_RUN;
          // The last flush cycle already fetches in-path, so capture it.
          if (!stall) capture = 1'b1;
        end else begin
          flush_left_d = flush_left_q - 3'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (flush_enter) begin
      state_d      = S_FLUSH;
      flush_left_d = FLUSH_INIT;
      valid_d      = 1'b0;
    end
    if (capture) begin
      instr_d = ifu_instr;
      valid_d = 1'b1;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign flushing    = (state_q == S_FLUSH);

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (capture && fetch_cnt_q != '1)     fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (flush_enter && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Two instances share the
// execute-side stimulus: u_dut (FLUSH_CYCLES=1) and u_dut3 (FLUSH_CYCLES=3),
// each driving its own small IFU model (load / +16 on taken branch / +4).
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0010_0008;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        stall, br_req, alu_zero, alu_msb, jmp_req;
  logic [1:0]  br_type;
  logic [31:0] jmp_target;

  logic [31:0] ifu_pc, ifu_instr, pc_data, instr_out;
  logic [1:0]  branch;
  logic        zero, msb, pc_ld, instr_valid, flushing;
  logic [15:0] fetch_cnt, flush_cnt;

  logic [31:0] ifu_pc3, ifu_instr3, pc_data3, instr_out3;
  logic [1:0]  branch3;
  logic        zero3, msb3, pc_ld3, instr_valid3, flushing3;
  logic [15:0] fetch_cnt3, flush_cnt3;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_req(br_req),
    .br_type(br_type), .alu_zero(alu_zero), .alu_msb(alu_msb),
    .jmp_req(jmp_req), .jmp_target(jmp_target), .ifu_pc(ifu_pc),
    .ifu_instr(ifu_instr), .ifu_branch(branch), .ifu_zero(zero),
    .ifu_msb(msb), .ifu_pc_ld(pc_ld), .ifu_pc_data(pc_data),
    .instr_out(instr_out), .instr_valid(instr_valid), .flushing(flushing),
    .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  fetch_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .stall(stall), .br_req(br_req),
    .br_type(br_type), .alu_zero(alu_zero), .alu_msb(alu_msb),
    .jmp_req(jmp_req), .jmp_target(jmp_target), .ifu_pc(ifu_pc3),
    .ifu_instr(ifu_instr3), .ifu_branch(branch3), .ifu_zero(zero3),
    .ifu_msb(msb3), .ifu_pc_ld(pc_ld3), .ifu_pc_data(pc_data3),
    .instr_out(instr_out3), .instr_valid(instr_valid3), .flushing(flushing3),
    .fetch_cnt(fetch_cnt3), .flush_cnt(flush_cnt3)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic logic taken(input logic [1:0] t, input logic z, input logic m);
    return (t == 2'b01 && z) || (t == 2'b10 && !z) || (t == 2'b11 && m);
  endfunction

  // IFU models
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                         ifu_pc <= '0;
    else if (pc_ld)                     ifu_pc <= pc_data;
    else if (taken(branch, zero, msb))  ifu_pc <= ifu_pc + 32'd16;
    else                                ifu_pc <= ifu_pc + 32'd4;

  always_ff @(posedge clk or negedge rst3_n)
    if (!rst3_n)                           ifu_pc3 <= '0;
    else if (pc_ld3)                       ifu_pc3 <= pc_data3;
    else if (taken(branch3, zero3, msb3))  ifu_pc3 <= ifu_pc3 + 32'd16;
    else                                   ifu_pc3 <= ifu_pc3 + 32'd4;

  assign ifu_instr  = instr_at(ifu_pc);
  assign ifu_instr3 = instr_at(ifu_pc3);

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    rst_n = 1'b0; rst3_n = 1'b0;
    stall = 1'b0; br_req = 1'b0; br_type = 2'b00; alu_zero = 1'b0;
    alu_msb = 1'b0; jmp_req = 1'b0; jmp_target = '0;

    // Reset held 3 cycles
    repeat (3) tick();
    check_eq("rst_pc_ld",    32'(pc_ld), 32'd1);
    check_eq("rst_pc_data",  pc_data, RV);
    check_eq("rst_branch",   32'({branch, zero, msb}), 32'd0);
    check_eq("rst_valid",    32'(instr_valid), 32'd0);
    check_eq("rst_instr",    instr_out, 32'd0);
    check_eq("rst_flushing", 32'(flushing), 32'd0);
    check_eq("rst_cnts",     {fetch_cnt, flush_cnt}, 32'd0);

    // Boot
    rst_n = 1'b1;
    #1 check_eq("boot_pc_ld_held", 32'(pc_ld), 32'd1);
    tick();
    check_eq("boot_pc",       ifu_pc, RV);
    check_eq("boot_valid0",   32'(instr_valid), 32'd0);
    check_eq("boot_pc_ld_off", 32'(pc_ld), 32'd0);
    tick();
    check_eq("boot_valid1",   32'(instr_valid), 32'd1);
    check_eq("boot_instr",    instr_out, instr_at(RV));
    check_eq("boot_pc_next",  ifu_pc, 32'h0010_000C);

    // Sequential run
    exp_pc = 32'h0010_000C;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      check_eq("seq_pc",    ifu_pc, exp_pc);
      check_eq("seq_instr", instr_out, instr_at(exp_pc - 32'd4));
      check_eq("seq_valid", 32'(instr_valid), 32'd1);
    end
    check_eq("seq_end_pc", ifu_pc, 32'h0010_0020);

    // beq taken
    br_req = 1'b1; br_type = 2'b01; alu_zero = 1'b1;
    #1 check_eq("beq_ctrl", 32'({branch, zero, msb, pc_ld}), 32'b01_1_0_0);
    tick();
    br_req = 1'b0; br_type = 2'b00; alu_zero = 1'b0;
    check_eq("beq_pc",       ifu_pc, 32'h0010_0030);
    check_eq("beq_flushing", 32'(flushing), 32'd1);
    check_eq("beq_bubble",   32'(instr_valid), 32'd0);
    tick();
    check_eq("beq_tgt_valid", 32'(instr_valid), 32'd1);
    check_eq("beq_tgt_instr", instr_out, instr_at(32'h0010_0030));
    check_eq("beq_flush_off", 32'(flushing), 32'd0);

    // bne not taken
    br_req = 1'b1; br_type = 2'b10; alu_zero = 1'b1;
    #1 check_eq("bne_ctrl", 32'({branch, zero, msb, pc_ld}), 32'b10_1_0_0);
    tick();
    br_req = 1'b0; br_type = 2'b00; alu_zero = 1'b0;
    check_eq("bne_valid",    32'(instr_valid), 32'd1);
    check_eq("bne_instr",    instr_out, instr_at(32'h0010_0034));
    check_eq("bne_flushing", 32'(flushing), 32'd0);
    check_eq("bne_pc",       ifu_pc, 32'h0010_0038);
    check_eq("bne_flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

    // Jump with concurrent branch request
    jmp_req = 1'b1; jmp_target = 32'h0010_0040;
    br_req = 1'b1; br_type = 2'b01; alu_zero = 1'b1;
    #1 check_eq("jmp_pc_data", pc_data, 32'h0010_0040);
    check_eq("jmp_ctrl", 32'({branch, pc_ld}), 32'b00_1);
    tick();
    jmp_req = 1'b0; br_req = 1'b0; br_type = 2'b00; alu_zero = 1'b0;
    check_eq("jmp_pc",     ifu_pc, 32'h0010_0040);
    check_eq("jmp_bubble", 32'(instr_valid), 32'd0);
    tick();
    check_eq("jmp_tgt_instr", instr_out, instr_at(32'h0010_0040));
    check_eq("jmp_tgt_valid", 32'(instr_valid), 32'd1);

    // Stall for 3 cycles
    stall = 1'b1;
    #1 check_eq("stall_pc_data", pc_data, 32'h0010_0044);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc",    ifu_pc, 32'h0010_0044);
      check_eq("stall_instr", instr_out, instr_at(32'h0010_0040));
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_pc",    ifu_pc, 32'h0010_0048);
    check_eq("unstall_instr", instr_out, instr_at(32'h0010_0044));
    check_eq("fetch_cnt",     32'(fetch_cnt), PERF ? 32'd10 : 32'd0);
    check_eq("flush_cnt",     32'(flush_cnt), PERF ? 32'd2 : 32'd0);

    // FLUSH_CYCLES=3 instance: jump, jump during flush, reset mid-flush
    rst3_n = 1'b1;
    tick();
    check_eq("f3_boot_pc", ifu_pc3, RV);
    tick();
    check_eq("f3_boot_valid", 32'(instr_valid3), 32'd1);
    jmp_req = 1'b1; jmp_target = 32'h0010_0100;
    tick();
    check_eq("f3_jmp_pc",   ifu_pc3, 32'h0010_0100);
    check_eq("f3_flush1",   32'({flushing3, instr_valid3}), 32'b10);
    jmp_target = 32'h0020_0000;  // jump request while flushing
    #1 check_eq("f3_ign_pc_ld", 32'(pc_ld3), 32'd0);
    check_eq("f3_ign_pc_data", pc_data3, 32'd0);
    tick();
    jmp_req = 1'b0;
    check_eq("f3_ign_pc", ifu_pc3, 32'h0010_0104);
    check_eq("f3_flush2", 32'({flushing3, instr_valid3}), 32'b10);
    check_eq("f3_flush_cnt", 32'(flush_cnt3), PERF ? 32'd1 : 32'd0);
    rst3_n = 1'b0;
    #1 check_eq("f3_rst_pc_ld", 32'(pc_ld3), 32'd1);
    check_eq("f3_rst_pc_data", pc_data3, RV);
    check_eq("f3_rst_flags", 32'({flushing3, instr_valid3, branch3}), 32'd0);
    check_eq("f3_rst_cnt",   32'(flush_cnt3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
